seq_word_serializer: RTL and testbench
======================================

Name: seq_word_serializer

Overview:
- Upstream feeder for the Mealy 101/110 sequence detector.
- Accepts parallel words over a valid/ready handshake and presents them one bit per consumed cycle on `d`, with `d_valid` qualifying each bit.
- A `bit_en` strobe sets the bit rate, so the detector can run at full clock rate or throttled.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word width in bits (2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_LEVEL, 0, value driven on `d` while no bit is valid.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- word_in  input  WIDTH  parallel word to serialize.
- word_valid  input  1  `word_in` is valid.
- word_ready  output  1  serializer accepts `word_in` this cycle (combinational).
- bit_en  input  1  consume the current bit at this edge.
- d  output  1  serial bit to the detector (registered).
- d_valid  output  1  `d` holds a valid bit (registered).
- busy  output  1  in SHIFT state (registered).
- done  output  1  one-cycle pulse after the last bit of a word is consumed (registered).

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, d=IDLE_LEVEL, d_valid=0, busy=0, done=0.
  - Shift register and counter cleared.
  - Any in-flight word is discarded; no done pulse.
  - rst has priority over every other input.
- Two-state FSM, IDLE and SHIFT. Remaining-bit counter `cnt` is clog2(WIDTH) bits wide.
- IDLE:
  - word_ready=1.
  - On edge with word_valid=1: load shift register; d<=first bit; d_valid<=1; cnt<=WIDTH-1; state<=SHIFT.
  - Loading does not require bit_en.
- SHIFT:
  - A bit is consumed at an edge where bit_en=1. With bit_en=0, d, d_valid and cnt hold.
  - Consume with cnt>0: d<=next bit per MSB_FIRST; cnt<=cnt-1.
  - Consume with cnt==0 (last bit): done<=1 for exactly the next cycle.
    - If word_valid=1 at the same edge: load the new word as in IDLE. d_valid stays 1 and the state stays SHIFT (zero-gap back-to-back).
    - Otherwise: state<=IDLE, d<=IDLE_LEVEL, d_valid<=0.
- word_ready = (state==IDLE) | (state==SHIFT & cnt==0 & bit_en). No handshake occurs elsewhere.
- `word_in` is sampled only at the accepting edge; later changes are ignored.
- Latency: with acceptance at edge k, the first bit appears on `d` in the cycle after k.
- With bit_en held at 1, a word occupies exactly WIDTH cycles on `d`.
- busy == (state==SHIFT); d_valid == busy.
- With bit_en=0 on the last bit, word_ready=0 and the word is held; no data is lost or duplicated.

Decomposition:
- Shared package `seq_pkg`:
  - FSM state encoding localparams (IDLE=1'b0, SHIFT=1'b1).
  - Counter-width function clog2.
  - The same package supplies the detector's state encodings.
- No sub-module needed. Shift register, counter and FSM live in one module (about 150 lines).

Test Plan:
- Reset values: assert rst for 2 cycles with word_valid=1 -> d=0, d_valid=0, busy=0, done=0, word_ready=1 after release; no load occurs while rst=1.
- Single word, MSB_FIRST=1, bit_en=1, word_in=8'b1011_0110:
  - d = 1,0,1,1,0,1,1,0 in cycles 1..8 after acceptance, d_valid=1 exactly those 8 cycles.
  - done=1 in cycle 9 only; then d=0.
- Back-to-back: 8'hA5 then 8'h3C, with word_valid held.
  - word_ready pulses on the last-bit cycle of the first word.
  - 16 contiguous valid bits 10100101_00111100, one done pulse after each word.
- Throttle: bit_en=1 every 3rd cycle, word 8'hC3.
  - Each bit is held 3 cycles; the bit order is unchanged.
  - word_ready stays 0 on the last bit until its bit_en edge.
- LSB-first (MSB_FIRST=0), word_in=8'b0000_0110 -> d = 0,1,1,0,0,0,0,0.
- Reset mid-word: rst at bit 4 of 8'hFF -> d=IDLE_LEVEL and d_valid=0 next cycle; no done pulse; next word serializes from its first bit.
- Integration with the detector: word 8'b0110_1101, MSB-first, bit_en=1 -> detector z asserts on exactly 4 bit cycles (bits 4,5,7,8).

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the serial sequence-detector path: serializer FSM states,
// detector state codes and the counter-width helper.
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Mealy 101/110 detector states, named after the suffix seen so far
    localparam logic [1:0] DET_S0  = 2'd0;
    localparam logic [1:0] DET_S1  = 2'd1;
    localparam logic [1:0] DET_S10 = 2'd2;
    localparam logic [1:0] DET_S11 = 2'd3;

    // Bits needed to hold values 0..n-1, never less than one
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial feeder: takes words over valid/ready and emits one bit per
// bit_en-qualified cycle on d, with zero-gap back-to-back loading on the last bit.
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             bit_en,
    output logic             d,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW      = clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic             r_d;
    logic             r_dv;
    logic             r_done;

    logic             w_consume;
    logic             w_last;
    logic             w_load;
    logic             w_first;
    logic             w_bit_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;

    assign w_consume  = (r_state == ST_SHIFT) & bit_en;
    assign w_last     = w_consume & (r_cnt == '0);
    assign word_ready = (r_state == ST_IDLE) | w_last;
    assign w_load     = word_ready & word_valid;

    // The bit on d is always the leading end of r_sreg; shifting exposes the next one
    assign w_first    = MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
    assign w_sreg_nxt = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
    assign w_bit_nxt  = MSB_FIRST ? r_sreg[WIDTH-2] : r_sreg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_d     <= IDLE_LEVEL;
            r_dv    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_state <= ST_SHIFT;
                r_sreg  <= word_in;
                r_cnt   <= CNT_MAX;
                r_d     <= w_first;
                r_dv    <= 1'b1;
            end else if (w_consume) begin
                if (r_cnt != '0) begin
                    r_sreg <= w_sreg_nxt;
                    r_cnt  <= r_cnt - 1'b1;
                    r_d    <= w_bit_nxt;
                end else begin
                    r_state <= ST_IDLE;
                    r_d     <= IDLE_LEVEL;
                    r_dv    <= 1'b0;
                end
            end
        end
    end

    assign d       = r_d;
    assign d_valid = r_dv;
    assign busy    = (r_state == ST_SHIFT);
    assign done    = r_done;

endmodule

// File: tb/tb_seq_word_serializer.sv
// Scoreboard bench for seq_word_serializer: expected bits are queued on acceptance
// and popped as the DUT consumes them; a small 101/110 model checks detector hits.
module tb_seq_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       bit_en;
    logic       d, d_valid, busy, done;

    logic [7:0] l_word;
    logic       l_valid;
    logic       l_ready, l_d, l_dv, l_busy, l_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int bitn     = 0;
    int en_mode  = 0;
    int ph       = 0;

    bit q[$];
    bit zlog[0:1023];
    logic [1:0] h;
    int  seen;
    logic prev_dv, prev_en, prev_d;

    always #5 clk = ~clk;

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .bit_en(bit_en), .d(d), .d_valid(d_valid),
        .busy(busy), .done(done)
    );

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .word_in(l_word), .word_valid(l_valid),
        .word_ready(l_ready), .bit_en(bit_en), .d(l_d), .d_valid(l_dv),
        .busy(l_busy), .done(l_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // bit_en pattern: mode 0 = every cycle, mode 1 = every third cycle
    initial begin
        bit_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph == 2) ? 0 : ph + 1;
            bit_en = (en_mode == 0) ? 1'b1 : (ph == 0);
        end
    end

    // Monitor: pops a queued bit on every consuming edge, runs the detector model
    always @(negedge clk) begin
        if (rst) begin
            h    = 2'b00;
            seen = 0;
            prev_dv = 1'b0;
        end else begin
            chk("dv_eq_busy", d_valid, busy);
            if (!d_valid) chk("idle_level", d, 1'b0);
            if (d_valid && prev_dv && !prev_en) chk("bit_hold", d, prev_d);
            if (d_valid && bit_en) begin
                if (q.size() == 0) chk("extra_bit", 1, 0);
                else chk("bit", d, q.pop_front());
                zlog[bitn & 1023] = (seen >= 2) && ({h, d} == 3'b101 || {h, d} == 3'b110);
                h = {h[0], d};
                seen++;
                bitn++;
            end
            if (done) n_done++;
            prev_dv = d_valid;
            prev_en = bit_en;
            prev_d  = d;
        end
    end

    task automatic send(input logic [7:0] w, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        word_in    = w;
        word_valid = 1'b1;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (word_ready) begin
                for (int i = 7; i >= 0; i--) q.push_back(w[i]);
                ok = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
        end
        #1;
        word_valid = 1'b0;
        word_in    = ~w;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    initial begin
        int w;
        int nd0;
        int b0;
        int zc;
        logic [7:0] zm;
        bit lexp[8];
        bit seen_done;

        rst = 1'b1; word_valid = 1'b1; word_in = 8'hFF;
        l_valid = 1'b0; l_word = 8'h00;
        h = 2'b00; seen = 0; prev_dv = 1'b0; prev_en = 1'b0; prev_d = 1'b0;

        // Reset held two cycles with a word offered: nothing may load
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_d", d, 0);
        chk("rst_dv", d_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0; word_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", word_ready, 1);
        chk("rst_noload", d_valid, 0);

        // Single word MSB-first
        @(posedge clk); #1;
        send(8'b1011_0110, w);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk("single_dv", d_valid, 1);
                chk("single_done_lo", done, 0);
            end else if (c == 9) begin
                chk("single_done", done, 1);
                chk("single_dv_end", d_valid, 0);
                chk("single_d_idle", d, 0);
            end else begin
                chk("single_done_once", done, 0);
            end
        end
        chk("single_drain", q.size(), 0);

        // Back-to-back with word_valid held
        @(posedge clk); #1;
        send(8'hA5, w);
        send(8'h3C, w);
        chk("b2b_ready_cycle", w, 7);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) chk("b2b_done1", done, 1);
            if (c <= 8) chk("b2b_dv", d_valid, 1);
            if (c == 9) begin
                chk("b2b_done2", done, 1);
                chk("b2b_dv_end", d_valid, 0);
            end
        end
        chk("b2b_drain", q.size(), 0);

        // Throttled: one consume every third cycle
        en_mode = 1;
        @(posedge clk); #1;
        send(8'hC3, w);
        seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            else if (busy && !bit_en) chk("thr_ready_lo", word_ready, 0);
        end
        chk("thr_done", seen_done, 1);
        chk("thr_drain", q.size(), 0);
        en_mode = 0;

        // LSB-first instance
        lexp = '{0, 1, 1, 0, 0, 0, 0, 0};
        @(posedge clk); #1;
        l_word = 8'b0000_0110; l_valid = 1'b1;
        @(negedge clk);
        chk("lsb_ready", l_ready, 1);
        @(posedge clk); #1;
        l_valid = 1'b0; l_word = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_dv", l_dv, 1);
            chk("lsb_bit", l_d, lexp[i]);
        end
        @(negedge clk);
        chk("lsb_done", l_done, 1);

        // Reset in the middle of a word
        @(posedge clk); #1;
        send(8'hFF, w);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        nd0 = n_done;
        @(posedge clk); #1;
        q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_d", d, 0);
        chk("mrst_dv", d_valid, 0);
        repeat (4) @(negedge clk);
        chk("mrst_no_done", n_done, nd0);
        @(posedge clk); #1;
        send(8'h96, w);
        repeat (10) @(negedge clk);
        chk("mrst_drain", q.size(), 0);

        // Detector integration from a fresh detector state
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        b0 = bitn;
        send(8'b0110_1101, w);
        repeat (10) @(negedge clk);
        zc = 0;
        for (int i = 0; i < 8; i++) begin
            zm[i] = zlog[(b0 + i) & 1023];
            if (zm[i]) zc++;
        end
        chk("det_count", zc, 4);
        chk("det_mask", zm, 8'b1101_1000);
        chk("final_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
